systolic_mac_pe: RTL

SYSTOLIC_MAC_PE -- requirements
Module: systolic_mac_pe

---
 rtl/systolic_pkg.sv | 17 +
 rtl/systolic_lane.sv | 49 ++++
 rtl/systolic_mac_pe.sv | 108 ++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants for the systolic MAC processing element: default geometry
// and the beat positions of the VALID/LAST flags inside a control word.
package systolic_pkg;

  localparam int DEF_LANE_W = 4;
  localparam int DEF_BEATS  = 4;
  localparam int DEF_ACC_W  = 40;

  // Flags are carried on the first beats of a block (beat 0 = word MSB).
  localparam int VALID_BEAT = 0;
  localparam int LAST_BEAT  = 1;

  function automatic int ctrl_bit(input int beats, input int beat);
    return beats - 1 - beat;
  endfunction

endpackage

// File: rtl/systolic_lane.sv
// One serial lane: gathers BEATS beats (MSB first) into a word and replays a
// word beat by beat during the following block.
import systolic_pkg::*;

module systolic_lane #(
  parameter int W        = 1,
  parameter int BEATS    = DEF_BEATS,
  parameter bit SER_ONLY = 1'b0,
  localparam int WORD_W  = W * BEATS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              boundary,
  input  logic [W-1:0]      din,
  input  logic [WORD_W-1:0] ext_word,
  output logic [WORD_W-1:0] word,
  output logic [W-1:0]      dout
);

  logic [(BEATS-1)*W-1:0] des_reg;
  logic [WORD_W-1:0]      ser_reg;

  // Complete word exists only combinationally on the boundary beat.
  assign word = {des_reg, din};

  generate
    if (BEATS == 2) begin : g_des_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) des_reg <= '0;
        else        des_reg <= din;
      end
    end else begin : g_des_shift
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) des_reg <= '0;
        else        des_reg <= {des_reg[(BEATS-2)*W-1:0], din};
      end
    end
  endgenerate

  // Zeros shift in behind the word so an empty block replays as all zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        ser_reg <= '0;
    else if (boundary) ser_reg <= SER_ONLY ? ext_word : word;
    else               ser_reg <= {ser_reg[WORD_W-W-1:0], {W{1'b0}}};
  end

  assign dout = ser_reg[WORD_W-1 -: W];

endmodule

// File: rtl/systolic_mac_pe.sv
// Systolic MAC processing element: forwards row/column operand and control
// lanes with one block of latency and accumulates row*col per valid block.
import systolic_pkg::*;

module systolic_mac_pe #(
  parameter int LANE_W  = DEF_LANE_W,
  parameter int BEATS   = DEF_BEATS,
  parameter int ACC_W   = DEF_ACC_W,
  localparam int WORD_W = LANE_W * BEATS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LANE_W-1:0] row_in,
  input  logic [LANE_W-1:0] col_in,
  input  logic              row_ctrl_in,
  input  logic              col_ctrl_in,
  output logic [LANE_W-1:0] row_out,
  output logic [LANE_W-1:0] col_out,
  output logic              row_ctrl_out,
  output logic              col_ctrl_out,
  output logic [LANE_W-1:0] res_out,
  output logic              res_ctrl_out
);

  localparam int CNT_W     = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int VALID_POS = ctrl_bit(BEATS, VALID_BEAT);
  localparam int LAST_POS  = ctrl_bit(BEATS, LAST_BEAT);

  logic [CNT_W-1:0]        cnt_reg;
  logic                    boundary;
  logic [WORD_W-1:0]       row_word, col_word, res_word, res_lane_unused;
  logic [BEATS-1:0]        row_cw, col_cw;
  logic                    ctrl_unused;
  logic                    mac_en, fire;
  logic signed [2*WORD_W-1:0] prod;
  logic signed [ACC_W-1:0] acc_reg, acc_sum;
  logic                    res_ctrl_reg;

  assign boundary = (cnt_reg == CNT_W'(BEATS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)        cnt_reg <= '0;
    else if (boundary) cnt_reg <= '0;
    else               cnt_reg <= cnt_reg + 1'b1;
  end

  systolic_lane #(.W(LANE_W), .BEATS(BEATS), .SER_ONLY(1'b0)) u_row_lane (
    .clk(clk), .rst_n(rst_n), .boundary(boundary), .din(row_in),
    .ext_word('0), .word(row_word), .dout(row_out)
  );

  systolic_lane #(.W(LANE_W), .BEATS(BEATS), .SER_ONLY(1'b0)) u_col_lane (
    .clk(clk), .rst_n(rst_n), .boundary(boundary), .din(col_in),
    .ext_word('0), .word(col_word), .dout(col_out)
  );

  systolic_lane #(.W(1), .BEATS(BEATS), .SER_ONLY(1'b0)) u_row_ctrl_lane (
    .clk(clk), .rst_n(rst_n), .boundary(boundary), .din(row_ctrl_in),
    .ext_word('0), .word(row_cw), .dout(row_ctrl_out)
  );

  systolic_lane #(.W(1), .BEATS(BEATS), .SER_ONLY(1'b0)) u_col_ctrl_lane (
    .clk(clk), .rst_n(rst_n), .boundary(boundary), .din(col_ctrl_in),
    .ext_word('0), .word(col_cw), .dout(col_ctrl_out)
  );

  // Reserved control bits and col LAST are forwarded only.
  assign ctrl_unused = ^{row_cw, col_cw};

  assign mac_en  = row_cw[VALID_POS] & col_cw[VALID_POS];
  assign fire    = row_cw[VALID_POS] & row_cw[LAST_POS];
  assign prod    = $signed(row_word) * $signed(col_word);
  assign acc_sum = acc_reg + (mac_en ? ACC_W'(prod) : '0);

  function automatic logic [WORD_W-1:0] saturate(input logic signed [ACC_W-1:0] v);
    if ((&v[ACC_W-1:WORD_W-1]) || !(|v[ACC_W-1:WORD_W-1]))
      return v[WORD_W-1:0];
    else if (v[ACC_W-1])
      return {1'b1, {(WORD_W-1){1'b0}}};
    else
      return {1'b0, {(WORD_W-1){1'b1}}};
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_reg <= '0;
    end else if (boundary) begin
      if (fire)        acc_reg <= '0;
      else if (mac_en) acc_reg <= acc_sum;
    end
  end

  // The result lane's serializer register doubles as the result buffer.
  assign res_word = fire ? saturate(acc_sum) : '0;

  systolic_lane #(.W(LANE_W), .BEATS(BEATS), .SER_ONLY(1'b1)) u_res_lane (
    .clk(clk), .rst_n(rst_n), .boundary(boundary), .din('0),
    .ext_word(res_word), .word(res_lane_unused), .dout(res_out)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) res_ctrl_reg <= 1'b0;
    else        res_ctrl_reg <= boundary & fire;
  end

  assign res_ctrl_out = res_ctrl_reg;

endmodule
